// File: rtl/bp_fe_pkg.sv
// Shared front-end types and helpers for the instruction realigner.
package bp_fe_pkg;

  localparam int fetch_word_width_gp = 32;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    SPLIT_WAIT,
    SPLIT
  } bp_fe_realigner_state_e;

  // Any 16-bit parcel whose low two bits are not 2'b11 starts an RVC instruction.
  function automatic logic is_rvc(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/bp_fe_instr_realigner.sv
// Splits aligned 32-bit fetch words into RVC / 32-bit instructions, stitching
// 32-bit instructions that straddle two consecutive fetch words.
module bp_fe_instr_realigner
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p = 39
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  flush_i,
  input  logic                                  fetch_v_i,
  input  logic [vaddr_width_p-1:0]              fetch_pc_i,
  input  logic [fetch_word_width_gp-1:0]        fetch_data_i,
  output logic                                  fetch_ready_o,
  output logic                                  v_o,
  output logic [fetch_word_width_gp-1:0]        instr_o,
  output logic [vaddr_width_p-1:0]              pc_o,
  output logic                                  compressed_o,
  input  logic                                  yumi_i
);

  bp_fe_realigner_state_e           state_r;
  logic [fetch_word_width_gp-1:0]   word_r;
  logic [vaddr_width_p-1:0]         wpc_r;
  logic [15:0]                      part_r;
  logic [vaddr_width_p-1:0]         ppc_r;

  logic                             lo_rvc;
  logic                             hi_rvc;
  logic [vaddr_width_p-1:0]         hi_pc;
  logic                             accept;
  bp_fe_realigner_state_e           accept_state;

  assign lo_rvc       = is_rvc(word_r[15:0]);
  assign hi_rvc       = is_rvc(word_r[31:16]);
  assign hi_pc        = wpc_r + vaddr_width_p'(2);
  assign accept       = fetch_v_i & fetch_ready_o;
  // A redirect may land on the upper half; the low half is then skipped.
  assign accept_state = fetch_pc_i[1] ? HI : LO;

  // Instruction outputs decode registered state only; ready may see yumi/flush.
  always_comb begin
    v_o           = 1'b0;
    instr_o       = '0;
    pc_o          = '0;
    compressed_o  = 1'b0;
    fetch_ready_o = 1'b0;
    case (state_r)
      IDLE: begin
        fetch_ready_o = 1'b1;
      end
      LO: begin
        v_o  = 1'b1;
        pc_o = wpc_r;
        if (lo_rvc) begin
          instr_o      = {16'b0, word_r[15:0]};
          compressed_o = 1'b1;
        end else begin
          instr_o       = word_r;
          fetch_ready_o = yumi_i;
        end
      end
      HI: begin
        if (hi_rvc) begin
          v_o           = 1'b1;
          instr_o       = {16'b0, word_r[31:16]};
          pc_o          = hi_pc;
          compressed_o  = 1'b1;
          fetch_ready_o = yumi_i;
        end else begin
          fetch_ready_o = 1'b1;
        end
      end
      SPLIT_WAIT: begin
        fetch_ready_o = 1'b1;
      end
      SPLIT: begin
        v_o     = 1'b1;
        instr_o = {word_r[15:0], part_r};
        pc_o    = ppc_r;
      end
      default: begin
        fetch_ready_o = 1'b0;
      end
    endcase
    if (flush_i) begin
      fetch_ready_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      word_r  <= '0;
      wpc_r   <= '0;
      part_r  <= '0;
      ppc_r   <= '0;
    end else if (flush_i) begin
      state_r <= IDLE;
      part_r  <= '0;
      ppc_r   <= '0;
    end else begin
      if (accept) begin
        word_r <= fetch_data_i;
        wpc_r  <= fetch_pc_i & ~vaddr_width_p'(3);
      end
      case (state_r)
        IDLE: begin
          if (accept) state_r <= accept_state;
        end
        LO: begin
          if (yumi_i) begin
            if (lo_rvc)      state_r <= HI;
            else if (accept) state_r <= accept_state;
            else             state_r <= IDLE;
          end
        end
        HI: begin
          if (hi_rvc) begin
            if (yumi_i) state_r <= accept ? accept_state : IDLE;
          end else begin
            // Park the leading half; word_r may be replaced by the next word now.
            part_r  <= word_r[31:16];
            ppc_r   <= hi_pc;
            state_r <= accept ? SPLIT : SPLIT_WAIT;
          end
        end
        SPLIT_WAIT: begin
          if (accept) state_r <= SPLIT;
        end
        SPLIT: begin
          if (yumi_i) state_r <= HI;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
